// File: rtl/convertidor_bcd_bin.sv
// Sequential 4-digit BCD to saturated binary converter using reverse double-dabble
// (shift right, subtract 3 from any BCD nibble >= 8) with a start/done handshake.
module convertidor_bcd_bin #(
  parameter int BUS = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           start,
  input  logic [15:0]    bcd_in,
  output logic           busy,
  output logic           done,
  output logic [BUS-1:0] num_bin,
  output logic           overflow,
  output logic           error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [13:0] MAX_C = 14'((32'd1 << BUS) - 32'd1);

  state_t           state_q, state_d;
  logic [29:0]      sr_q, sr_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [BUS-1:0]   num_q, num_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [29:0]      step_s;
  logic [13:0]      v_s;

  function automatic logic any_bad_digit(input logic [15:0] b);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (b[4*i +: 4] > 4'd9) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  // One iteration: shift right, then pull each BCD nibble back by 3 when it reached 8 or more.
  function automatic logic [29:0] dabble_step(input logic [29:0] s);
    logic [29:0] t;
    t = s >> 1;
    for (int i = 0; i < 4; i++) begin
      if (t[14+4*i +: 4] >= 4'd8) begin
        t[14+4*i +: 4] = t[14+4*i +: 4] - 4'd3;
      end else begin
        t[14+4*i +: 4] = t[14+4*i +: 4];
      end
    end
    return t;
  endfunction

  assign step_s = dabble_step(sr_q);
  assign v_s    = step_s[13:0];

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sr_q    <= 30'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      num_q   <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      num_q   <= num_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    num_d   = num_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (any_bad_digit(bcd_in)) begin
            err_d   = 1'b1;
            num_d   = '0;
            ovf_d   = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            sr_d    = {bcd_in, 14'd0};
            cnt_d   = 4'd0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            busy_d  = 1'b1;
            state_d = CONV;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        sr_d  = step_s;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) begin
          done_d  = 1'b1;
          state_d = DONE;
          // Saturation decision uses the full 14-bit value, before truncation to BUS.
          if (v_s > MAX_C) begin
            num_d = '1;
            ovf_d = 1'b1;
          end else begin
            num_d = v_s[BUS-1:0];
            ovf_d = 1'b0;
          end
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign num_bin  = num_q;
  assign overflow = ovf_q;
  assign error    = err_q;

endmodule

// File: tb/tb_convertidor_bcd_bin.sv
// Scoreboard bench for convertidor_bcd_bin: BUS=8 and BUS=14 instances driven in parallel.
module tb_convertidor_bcd_bin;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b1;
  logic        start   = 1'b0;
  logic [15:0] bcd_in  = 16'h0000;

  logic        busy8, done8, ovf8, err8;
  logic [7:0]  num8;
  logic        busy14, done14, ovf14, err14;
  logic [13:0] num14;

  typedef struct {
    logic [7:0]  num8;
    logic        ovf8;
    logic        err;
    logic [13:0] num14;
    logic        ovf14;
    int          t0;
    int          lat;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   cyc    = 0;

  convertidor_bcd_bin #(.BUS(8)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .bcd_in(bcd_in),
    .busy(busy8), .done(done8), .num_bin(num8), .overflow(ovf8), .error(err8)
  );

  convertidor_bcd_bin #(.BUS(14)) dut14 (
    .clock(clock), .reset_n(reset_n), .start(start), .bcd_in(bcd_in),
    .busy(busy14), .done(done14), .num_bin(num14), .overflow(ovf14), .error(err14)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [15:0] b, input int t0);
    exp_t e;
    int   v;
    bit   bad;
    bad = 1'b0;
    v   = 0;
    for (int i = 3; i >= 0; i--) begin
      if (b[4*i +: 4] > 4'd9) bad = 1'b1;
      v = v * 10 + int'(b[4*i +: 4]);
    end
    e.t0 = t0;
    if (bad) begin
      e.err = 1'b1; e.num8 = 8'd0; e.ovf8 = 1'b0; e.num14 = 14'd0; e.ovf14 = 1'b0; e.lat = 1;
    end else begin
      e.err   = 1'b0;
      e.ovf8  = (v > 255);
      e.num8  = (v > 255) ? 8'hFF : 8'(v);
      e.num14 = 14'(v);
      e.ovf14 = 1'b0;
      e.lat   = 15;
    end
    return e;
  endfunction

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  // Output monitor: pops the scoreboard on every done pulse
  always @(negedge clock) begin
    exp_t e;
    chk("busy_done_excl", {31'd0, busy8 & done8}, 32'd0);
    if (done8 === 1'b1 || done14 === 1'b1) begin
      chk("done_bus14_align", {31'd0, done14}, {31'd0, done8});
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("num_bin8",   {24'd0, num8},  {24'd0, e.num8});
        chk("overflow8",  {31'd0, ovf8},  {31'd0, e.ovf8});
        chk("error8",     {31'd0, err8},  {31'd0, e.err});
        chk("num_bin14",  {18'd0, num14}, {18'd0, e.num14});
        chk("overflow14", {31'd0, ovf14}, {31'd0, e.ovf14});
        chk("error14",    {31'd0, err14}, {31'd0, e.err});
        chk("latency",    cyc - e.t0,     e.lat);
      end
      n_done++;
    end
  end

  task automatic wait_done(input int target);
    for (int k = 0; k < 60 && n_done < target; k++) begin
      @(negedge clock);
      #1;
    end
    chk("done_timeout", {31'd0, n_done >= target}, 32'd1);
  endtask

  task automatic run(input logic [15:0] b);
    int d0;
    @(negedge clock);
    bcd_in = b;
    start  = 1'b1;
    sb_q.push_back(model(b, cyc));
    d0 = n_done;
    @(negedge clock);
    start = 1'b0;
    #1;
    wait_done(d0 + 1);
    @(negedge clock);
  endtask

  initial begin
    int          d0;
    int          s;
    logic [15:0] b;

    // Asynchronous reset with no clock edge involved
    #1 reset_n = 1'b0;
    #1;
    chk("rst_busy",  {31'd0, busy8}, 32'd0);
    chk("rst_done",  {31'd0, done8}, 32'd0);
    chk("rst_num",   {24'd0, num8},  32'd0);
    chk("rst_ovf",   {31'd0, ovf8},  32'd0);
    chk("rst_err",   {31'd0, err8},  32'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    run(16'h0255);
    run(16'h0256);
    run(16'h9999);
    run(16'h0000);
    run(16'h0128);
    run(16'h12A4);
    run(16'h0077);

    // A start pulse during CONV is ignored
    @(negedge clock);
    bcd_in = 16'h0042;
    start  = 1'b1;
    sb_q.push_back(model(16'h0042, cyc));
    d0 = n_done;
    @(negedge clock);
    start = 1'b0;
    repeat (6) @(negedge clock);
    bcd_in = 16'h0099;
    start  = 1'b1;
    @(negedge clock);
    start  = 1'b0;
    bcd_in = 16'h0000;
    #1;
    wait_done(d0 + 1);
    repeat (20) @(negedge clock);
    chk("ignored_start_sb_empty", sb_q.size(), 32'd0);

    // start held high: re-accepted 16 cycles later
    @(negedge clock);
    bcd_in = 16'h0012;
    start  = 1'b1;
    s      = cyc;
    sb_q.push_back(model(16'h0012, s));
    sb_q.push_back(model(16'h0012, s + 16));
    d0 = n_done;
    repeat (17) @(negedge clock);
    start = 1'b0;
    #1;
    wait_done(d0 + 2);
    @(negedge clock);

    for (int i = 0; i < 256; i++) run(to_bcd(i));

    for (int i = 0; i < 24; i++) begin
      b = to_bcd(int'($urandom_range(9999, 0)));
      if (i % 4 == 3) b[4*(i%16/4) +: 4] = 4'($urandom_range(15, 10));
      run(b);
    end

    // Asynchronous reset in the middle of a conversion
    @(negedge clock);
    bcd_in = 16'h0300;
    start  = 1'b1;
    sb_q.push_back(model(16'h0300, cyc));
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy",  {31'd0, busy8},  32'd0);
    chk("abort_done",  {31'd0, done8},  32'd0);
    chk("abort_num",   {24'd0, num8},   32'd0);
    chk("abort_ovf",   {31'd0, ovf8},   32'd0);
    chk("abort_err",   {31'd0, err8},   32'd0);
    chk("abort_num14", {18'd0, num14},  32'd0);
    sb_q.delete();
    repeat (20) @(negedge clock);
    reset_n = 1'b1;
    repeat (20) @(negedge clock);
    run(16'h0042);
    run(16'h9999);

    chk("final_sb_empty", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
